// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with an early-exit path for illegal/div-by-zero/overflow.
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FAST, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic            r_sa, r_sb;
  logic [W-1:0]    r_opd;
  logic [2*W-1:0]  r_acc;
  logic [W:0]      r_rem;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_result;

  logic            w_accept, w_legal, w_is_div, w_sa, w_sb, w_div0, w_ovf, w_fast;
  logic [2:0]      w_op3;
  logic [W-1:0]    w_mag_a, w_mag_b, w_fast_res;
  logic [W-1:0]    w_addend, w_quot_nxt, w_calc_res;
  logic [W:0]      w_sum, w_shift, w_rem_nxt;
  logic [2*W-1:0]  w_mul_nxt, w_prod_s;
  logic            w_ge;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Accept-time decode: magnitudes, signs and the early-exit result
  always_comb begin
    w_op3    = Operation[2:0];
    w_legal  = ((Operation >> 3) == '0);
    w_is_div = w_op3[2];
    w_sa     = w_legal && (w_op3 == 3'd1 || w_op3 == 3'd2 || w_op3 == 3'd4 || w_op3 == 3'd6)
               && SrcA[W-1];
    w_sb     = w_legal && (w_op3 == 3'd1 || w_op3 == 3'd4 || w_op3 == 3'd6) && SrcB[W-1];
    w_mag_a  = neg_w(SrcA, w_sa);
    w_mag_b  = neg_w(SrcB, w_sb);
    w_div0   = w_legal && w_is_div && (SrcB == '0);
    w_ovf    = w_legal && (w_op3 == 3'd4 || w_op3 == 3'd6)
               && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
    w_fast   = !w_legal || w_div0 || w_ovf;
    w_fast_res = '0;
    if (w_div0)     w_fast_res = w_op3[1] ? SrcA : '1;
    else if (w_ovf) w_fast_res = w_op3[1] ? '0 : SrcA;
    w_accept = (r_state == S_IDLE) && start && !flush;
  end

  // One iteration: multiply uses the full accumulator, divide uses its low half as quotient
  always_comb begin
    w_addend   = r_acc[0] ? r_opd : '0;
    w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
    w_mul_nxt  = {w_sum, r_acc[W-1:1]};
    w_shift    = {r_rem[W-1:0], r_acc[W-1]};
    w_ge       = (w_shift >= {1'b0, r_opd});
    w_rem_nxt  = w_ge ? (w_shift - {1'b0, r_opd}) : w_shift;
    w_quot_nxt = {r_acc[W-2:0], w_ge};
    w_prod_s   = neg_2w(w_mul_nxt, r_sa ^ r_sb);
    if (!r_op[2])     w_calc_res = (r_op[1:0] == 2'd0) ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];
    else if (r_op[1]) w_calc_res = neg_w(w_rem_nxt[W-1:0], r_sa);
    else              w_calc_res = neg_w(w_quot_nxt, r_sa ^ r_sb);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_fast ? S_FAST : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_FAST: w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_opd    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= w_op3;
      r_sa  <= w_sa;
      r_sb  <= w_sb;
      r_opd <= w_is_div ? w_mag_b : w_mag_a;
      r_acc <= {{W{1'b0}}, (w_fast ? w_fast_res : (w_is_div ? w_mag_a : w_mag_b))};
      r_rem <= '0;
      r_cnt <= CW'(W);
    end else if (r_state == S_CALC) begin
      if (!r_op[2]) begin
        r_acc <= w_mul_nxt;
      end else begin
        r_acc[W-1:0] <= w_quot_nxt;
        r_rem        <= w_rem_nxt;
      end
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1) && !flush) r_result <= w_calc_res;
    end else if (r_state == S_FAST && !flush) begin
      r_result <= r_acc[W-1:0];
    end
  end

  assign busy   = (r_state == S_CALC) || (r_state == S_FAST);
  assign done   = (r_state == S_DONE);
  assign Result = r_result;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed scenarios plus a randomized sweep on W=32 and
// W=16 instances, checked against an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset_n, flush;
  logic        start32, start16;
  logic [3:0]  op32, op16;
  logic [31:0] a32, b32, res32;
  logic [15:0] a16, b16, res16;
  logic        busy32, done32, busy16, done16;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .flush(flush), .Operation(op32),
    .SrcA(a32), .SrcB(b32), .busy(busy32), .done(done32), .Result(res32));

  alu_muldiv #(.DATA_WIDTH(16), .OPCODE_LENGTH(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .flush(1'b0), .Operation(op16),
    .SrcA(a16), .SrcB(b16), .busy(busy16), .done(done16), .Result(res16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic
  function automatic logic [31:0] ref_model(input int w, input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint mask, ua, ub, sa, sb, r;
    logic [63:0] pu;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    case (op)
      4'd0: r = sa * sb;
      4'd1: r = (sa * sb) >>> w;
      4'd2: r = (sa * ub) >>> w;
      4'd3: begin pu = 64'(ua) * 64'(ub); r = longint'(pu >> w); end
      4'd4: r = (ub == 0) ? mask :
                ((sa == -(longint'(1) << (w-1)) && sb == -1) ? ua : sa / sb);
      4'd5: r = (ub == 0) ? mask : ua / ub;
      4'd6: r = (ub == 0) ? ua :
                ((sa == -(longint'(1) << (w-1)) && sb == -1) ? 0 : sa % sb);
      4'd7: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic bit is_fast(input int w, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    longint mask, ua, ub;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    if (op > 4'd7) return 1'b1;
    if (op >= 4'd4 && ub == 0) return 1'b1;
    if ((op == 4'd4 || op == 4'd6) && ua == (longint'(1) << (w-1)) && ub == mask) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rnd_operand(input int w);
    longint mask;
    mask = (longint'(1) << w) - 1;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'(mask);
      2: return 32'(longint'(1) << (w-1));
      3: return 32'($urandom_range(1, 9));
      default: return 32'(longint'($urandom) & mask);
    endcase
  endfunction

  function automatic logic [3:0] rnd_op();
    int s;
    s = $urandom_range(0, 8);
    return (s == 8) ? 4'($urandom_range(8, 15)) : 4'(s);
  endfunction

  task automatic run_pair(input logic [3:0] o32, input logic [31:0] x32, input logic [31:0] y32,
                          input logic [3:0] o16, input logic [15:0] x16, input logic [15:0] y16,
                          output logic [31:0] got);
    logic [31:0] exp32, exp16, g16;
    int lat32, lat16, n32, n16, f32, f16;
    bit overlap;
    exp32 = ref_model(32, o32, x32, y32);
    exp16 = ref_model(16, o16, {16'h0, x16}, {16'h0, y16});
    lat32 = is_fast(32, o32, x32, y32) ? 1 : 32;
    lat16 = is_fast(16, o16, {16'h0, x16}, {16'h0, y16}) ? 1 : 16;
    op32 = o32; a32 = x32; b32 = y32; op16 = o16; a16 = x16; b16 = y16;
    start32 = 1'b1; start16 = 1'b1;
    tick();
    start32 = 1'b0; start16 = 1'b0;
    check("busy_after_accept", {30'd0, busy32, busy16}, 32'd3);
    n32 = 0; n16 = 0; f32 = -1; f16 = -1; overlap = 1'b0; got = '0; g16 = '0;
    for (int n = 1; n <= 36; n++) begin
      tick();
      if (done32) begin n32++; if (f32 < 0) begin f32 = n; got = res32; end end
      if (done16) begin n16++; if (f16 < 0) begin f16 = n; g16 = {16'h0, res16}; end end
      if ((busy32 && done32) || (busy16 && done16)) overlap = 1'b1;
    end
    check("latency32", 32'(f32), 32'(lat32));
    check("done_count32", 32'(n32), 32'd1);
    check("result32", got, exp32);
    check("latency16", 32'(f16), 32'(lat16));
    check("done_count16", 32'(n16), 32'd1);
    check("result16", g16, exp16);
    check("busy_done_overlap", {31'd0, overlap}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int nd;
    reset_n = 1'b0; flush = 1'b0; start32 = 1'b0; start16 = 1'b0;
    op32 = '0; op16 = '0; a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    tick(); tick();
    check("reset_busy", {30'd0, busy32, busy16}, 32'd0);
    check("reset_done", {30'd0, done32, done16}, 32'd0);
    check("reset_result32", res32, 32'd0);
    check("reset_result16", {16'h0, res16}, 32'd0);
    reset_n = 1'b1;
    tick();

    run_pair(4'd0, 32'h7, 32'hFFFFFFFD, 4'd0, 16'h7, 16'hFFFD, r);
    check("mul_7_m3", r, 32'hFFFFFFEB);
    run_pair(4'd1, 32'h7, 32'hFFFFFFFD, 4'd1, 16'h7, 16'hFFFD, r);
    check("mulh_7_m3", r, 32'hFFFFFFFF);
    run_pair(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 16'hFFFF, 16'hFFFF, r);
    check("mulhu_max", r, 32'hFFFFFFFE);
    run_pair(4'd4, 32'hFFFFFFF9, 32'h2, 4'd4, 16'hFFF9, 16'h2, r);
    check("div_m7_2", r, 32'hFFFFFFFD);
    run_pair(4'd6, 32'hFFFFFFF9, 32'h2, 4'd6, 16'hFFF9, 16'h2, r);
    check("rem_m7_2", r, 32'hFFFFFFFF);
    run_pair(4'd5, 32'h80000000, 32'h3, 4'd5, 16'h8000, 16'h3, r);
    check("divu_min_3", r, 32'h2AAAAAAA);
    run_pair(4'd7, 32'h80000000, 32'h3, 4'd7, 16'h8000, 16'h3, r);
    check("remu_min_3", r, 32'h00000002);
    run_pair(4'd4, 32'h80000000, 32'hFFFFFFFF, 4'd4, 16'h8000, 16'hFFFF, r);
    check("div_overflow", r, 32'h80000000);
    run_pair(4'd6, 32'h80000000, 32'hFFFFFFFF, 4'd6, 16'h8000, 16'hFFFF, r);
    check("rem_overflow", r, 32'h0);
    run_pair(4'd5, 32'h5, 32'h0, 4'd5, 16'h5, 16'h0, r);
    check("divu_by_zero", r, 32'hFFFFFFFF);
    run_pair(4'd7, 32'h5, 32'h0, 4'd7, 16'h5, 16'h0, r);
    check("remu_by_zero", r, 32'h5);

    // Second start mid-multiply must be ignored
    op32 = 4'd0; a32 = 32'd12345; b32 = 32'd678; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    nd = 0; r = '0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin op32 = 4'd5; a32 = 32'd99; b32 = 32'd4; start32 = 1'b1; end
      tick();
      start32 = 1'b0;
      if (done32) begin nd++; if (nd == 1) begin r = res32; check("restart_latency", 32'(n), 32'd32); end end
    end
    check("restart_done_count", 32'(nd), 32'd1);
    check("restart_result", r, ref_model(32, 4'd0, 32'd12345, 32'd678));

    // Flush at cycle 12 of a multiply
    op32 = 4'd0; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int n = 1; n <= 11; n++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy32}, 32'd0);
    nd = 0;
    for (int n = 0; n < 30; n++) begin tick(); if (done32) nd++; end
    check("flush_no_done", 32'(nd), 32'd0);
    check("flush_result_kept", res32, ref_model(32, 4'd0, 32'd12345, 32'd678));

    // Flush together with start in IDLE blocks the request
    op32 = 4'd0; a32 = 32'd2; b32 = 32'd2; start32 = 1'b1; flush = 1'b1;
    tick();
    start32 = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy32}, 32'd0);
    nd = 0;
    for (int n = 0; n < 4; n++) begin tick(); if (done32) nd++; end
    check("flush_start_no_done", 32'(nd), 32'd0);

    // Reset at cycle 20 of a divide
    op32 = 4'd4; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int n = 1; n <= 19; n++) tick();
    reset_n = 1'b0;
    tick();
    check("midreset_busy", {31'd0, busy32}, 32'd0);
    check("midreset_done", {31'd0, done32}, 32'd0);
    check("midreset_result", res32, 32'd0);
    reset_n = 1'b1;
    tick();
    run_pair(4'd2, 32'hFFFFFFFF, 32'h2, 4'd2, 16'hFFFF, 16'h2, r);
    check("mulhsu_m1_2", r, 32'hFFFFFFFF);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x, y, u, v;
      x = rnd_operand(32); y = rnd_operand(32);
      u = rnd_operand(16); v = rnd_operand(16);
      run_pair(rnd_op(), x, y, rnd_op(), u[15:0], v[15:0], r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
